// File: rtl/dcm_phase_pkg.sv
// Shared types and default constants for the DCM variable phase-shift controller.
package dcm_phase_pkg;

    localparam int PHASE_WIDTH_DEF = 9;
    localparam int PHASE_MIN_DEF   = -255;
    localparam int PHASE_MAX_DEF   = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/phase_sat.sv
// Signed absolute/relative target select with saturation to [MIN, MAX].
module phase_sat
    import dcm_phase_pkg::*;
#(
    parameter int W   = PHASE_WIDTH_DEF,
    parameter int MIN = PHASE_MIN_DEF,
    parameter int MAX = PHASE_MAX_DEF
) (
    input  logic                rel,
    input  logic signed [W-1:0] base,
    input  logic signed [W-1:0] delta,
    output logic signed [W-1:0] result
);

    localparam logic signed [W:0] MIN_X = (W+1)'(MIN);
    localparam logic signed [W:0] MAX_X = (W+1)'(MAX);

    logic signed [W:0] base_x;
    logic signed [W:0] delta_x;
    logic signed [W:0] sum;

    // One extra bit means the relative sum can never wrap before the clamp.
    always_comb begin
        base_x  = $signed({base[W-1], base});
        delta_x = $signed({delta[W-1], delta});
        sum     = rel ? (base_x + delta_x) : delta_x;
        if (sum < MIN_X) begin
            result = MIN_X[W-1:0];
        end else if (sum > MAX_X) begin
            result = MAX_X[W-1:0];
        end else begin
            result = sum[W-1:0];
        end
    end

endmodule

// File: rtl/dcm_phase_ctrl.sv
// Walks the DCM variable phase one tap per PSEN/PSDONE handshake toward a clamped target.
// Optional WAIT timeout with sticky err is enabled by defining DCM_PHASE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | decide: step toward tgt_phase when locked, DCM ready and cur != tgt
// ACK     | dcm_en dropped; absorbs the wrapper's dcm_done fall
// WAIT    | wait for dcm_done high, then count the tap
module dcm_phase_ctrl
    import dcm_phase_pkg::*;
#(
    parameter int PHASE_WIDTH    = PHASE_WIDTH_DEF,
    parameter int PHASE_MIN      = PHASE_MIN_DEF,
    parameter int PHASE_MAX      = PHASE_MAX_DEF,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                          dcm_clk,
    input  logic                          dcm_rst,
    input  logic                          locked,
    input  logic                          set_stb,
    input  logic                          set_rel,
    input  logic signed [PHASE_WIDTH-1:0] set_phase,
    input  logic                          clr_err,
    output logic                          dcm_en,
    output logic                          dcm_incdec,
    input  logic                          dcm_done,
    output logic signed [PHASE_WIDTH-1:0] cur_phase,
    output logic signed [PHASE_WIDTH-1:0] tgt_phase,
    output logic                          busy,
    output logic                          err
);

    localparam logic signed [PHASE_WIDTH-1:0] ONE = PHASE_WIDTH'(1);

    state_t                          state_q, state_d;
    logic signed [PHASE_WIDTH-1:0]   cur_q, cur_d;
    logic signed [PHASE_WIDTH-1:0]   tgt_q, tgt_d;
    logic signed [PHASE_WIDTH-1:0]   tgt_load;
    logic                            en_q, en_d;
    logic                            incdec_q, incdec_d;

`ifdef DCM_PHASE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
`endif

    phase_sat #(
        .W   (PHASE_WIDTH),
        .MIN (PHASE_MIN),
        .MAX (PHASE_MAX)
    ) u_phase_sat (
        .rel    (set_rel),
        .base   (tgt_q),
        .delta  (set_phase),
        .result (tgt_load)
    );

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = set_stb ? tgt_load : tgt_q;
        en_d     = 1'b0;
        incdec_d = incdec_q;
`ifdef DCM_PHASE_TIMEOUT_EN
        cnt_d    = cnt_q;
        timeout  = 1'b0;
`endif
        // The DCM relocks at PHASE_SHIFT 0, so the applied count restarts there.
        if (!locked) begin
            state_d = ST_IDLE;
            cur_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dcm_done && (cur_q != tgt_q)) begin
                        en_d     = 1'b1;
                        incdec_d = (tgt_q > cur_q);
                        state_d  = ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_d = ST_WAIT;
`ifdef DCM_PHASE_TIMEOUT_EN
                    cnt_d   = CNT_LOAD;
`endif
                end
                ST_WAIT: begin
                    if (dcm_done) begin
                        cur_d   = incdec_q ? (cur_q + ONE) : (cur_q - ONE);
                        state_d = ST_IDLE;
                    end
`ifdef DCM_PHASE_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        timeout = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef DCM_PHASE_TIMEOUT_EN
        err_d = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge dcm_clk or posedge dcm_rst) begin
        if (dcm_rst) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            tgt_q    <= '0;
            en_q     <= 1'b0;
            incdec_q <= 1'b0;
`ifdef DCM_PHASE_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            en_q     <= en_d;
            incdec_q <= incdec_d;
`ifdef DCM_PHASE_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign dcm_en     = en_q;
    assign dcm_incdec = incdec_q;
    assign cur_phase  = cur_q;
    assign tgt_phase  = tgt_q;
    assign busy       = (state_q != ST_IDLE) || (cur_q != tgt_q);
`ifdef DCM_PHASE_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_dcm_phase_ctrl.sv
// Scoreboard bench for dcm_phase_ctrl: target walk model, DCM responder, lock loss and reset cases.
module tb_dcm_phase_ctrl;

    localparam int W    = 9;
    localparam int PMIN = -255;
    localparam int PMAX = 255;
    localparam int TMO  = 1023;

    logic                dcm_clk   = 1'b0;
    logic                dcm_rst   = 1'b1;
    logic                locked    = 1'b0;
    logic                set_stb   = 1'b0;
    logic                set_rel   = 1'b0;
    logic signed [W-1:0] set_phase = '0;
    logic                clr_err   = 1'b0;
    logic                dcm_done  = 1'b1;
    logic                dcm_en;
    logic                dcm_incdec;
    logic signed [W-1:0] cur_phase;
    logic signed [W-1:0] tgt_phase;
    logic                busy;
    logic                err;

    int total = 0;
    int bad   = 0;
    int exp_tgt_q[$];
    int drv_tgt       = 0;
    int en_count      = 0;
    int lat           = 4;
    bit rand_lat      = 1'b0;
    bit never_respond = 1'b0;

    dcm_phase_ctrl #(
        .PHASE_WIDTH    (W),
        .PHASE_MIN      (PMIN),
        .PHASE_MAX      (PMAX),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .dcm_clk    (dcm_clk),
        .dcm_rst    (dcm_rst),
        .locked     (locked),
        .set_stb    (set_stb),
        .set_rel    (set_rel),
        .set_phase  (set_phase),
        .clr_err    (clr_err),
        .dcm_en     (dcm_en),
        .dcm_incdec (dcm_incdec),
        .dcm_done   (dcm_done),
        .cur_phase  (cur_phase),
        .tgt_phase  (tgt_phase),
        .busy       (busy),
        .err        (err)
    );

    always #5 dcm_clk = ~dcm_clk;

    function automatic int clamp(int v);
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(bit rel, int val);
        @(negedge dcm_clk);
        set_stb   = 1'b1;
        set_rel   = rel;
        set_phase = W'(val);
        drv_tgt   = clamp(rel ? drv_tgt + val : val);
        exp_tgt_q.push_back(drv_tgt);
        @(negedge dcm_clk);
        set_stb   = 1'b0;
    endtask

    task automatic wait_idle(int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge dcm_clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL settle_timeout: busy still 1 after %0d cycles", maxc);
        end
    endtask

    task automatic wait_en(int maxc);
        int n = 0;
        while (!dcm_en && n < maxc) begin
            @(negedge dcm_clk);
            n++;
        end
        if (!dcm_en) begin
            total++;
            bad++;
            $display("FAIL en_timeout: no dcm_en within %0d cycles", maxc);
        end
    endtask

    // DCM wrapper model: ready drops after PSEN, returns after the PSDONE latency.
    initial begin
        int l;
        int n;
        forever begin
            @(negedge dcm_clk);
            if (dcm_en) begin
                dcm_done = 1'b0;
                l = rand_lat ? int'($urandom_range(1, 5)) : lat;
                n = 0;
                while (never_respond && n < 5000) begin
                    @(negedge dcm_clk);
                    n++;
                end
                repeat (l) @(negedge dcm_clk);
                dcm_done = 1'b1;
            end
        end
    end

    // Monitor: reference walk toward the target, one tap per handshake.
    initial begin
        int ref_cur   = 0;
        int ref_tgt   = 0;
        int prev_cur  = 0;
        int e;
        bit pending   = 1'b0;
        bit dir       = 1'b0;
        bit prev_en   = 1'b0;
        bit prev_busy = 1'b0;
        bit s_stb;
        bit s_lk;
        bit s_rst;
        forever begin
            @(posedge dcm_clk);
            s_stb = set_stb;
            s_lk  = locked;
            s_rst = dcm_rst;
            #1;
            if (s_rst || dcm_rst) begin
                ref_cur = 0; ref_tgt = 0; prev_cur = 0;
                pending = 0; prev_en = 0; prev_busy = 0;
                exp_tgt_q.delete();
                continue;
            end
            if (!s_lk) begin
                check("unlock_cur", int'(cur_phase), 0);
                check("unlock_en", int'(dcm_en), 0);
                ref_cur = 0;
                pending = 0;
            end else begin
                if (int'(cur_phase) != prev_cur) begin
                    check("step_pending", int'(pending), 1);
                    ref_cur = ref_cur + (dir ? 1 : -1);
                    check("cur_step", int'(cur_phase), ref_cur);
                    pending = 0;
                end
                if (dcm_en) begin
                    en_count++;
                    check("en_adjacent", int'(prev_en), 0);
                    check("step_needed", int'(ref_cur != ref_tgt), 1);
                    check("step_dir", int'(dcm_incdec), int'(ref_tgt > ref_cur));
                    pending = 1;
                    dir     = dcm_incdec;
                end
            end
            if (s_stb) begin
                if (exp_tgt_q.size() == 0) begin
                    check("tgt_queue_empty", 0, 1);
                end else begin
                    e = exp_tgt_q.pop_front();
                    check("tgt_load", int'(tgt_phase), e);
                    ref_tgt = e;
                end
            end
            if (ref_cur != ref_tgt) check("busy_flag", int'(busy), 1);
            if (prev_busy && !busy) check("settle_cur", int'(cur_phase), ref_tgt);
            prev_cur  = int'(cur_phase);
            prev_en   = dcm_en;
            prev_busy = busy;
        end
    end

    initial begin
        int c0;
        int c1;
        int n;
        int v;
        bit rel;
        int saved;

        repeat (3) @(negedge dcm_clk);
        check("rst_cur", int'(cur_phase), 0);
        check("rst_tgt", int'(tgt_phase), 0);
        check("rst_en", int'(dcm_en), 0);
        check("rst_incdec", int'(dcm_incdec), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        dcm_rst = 1'b0;
        locked  = 1'b1;
        repeat (2) @(negedge dcm_clk);

        // Absolute +3.
        c0 = en_count;
        load(1'b0, 3);
        wait_idle(200);
        check("abs3_pulses", en_count - c0, 3);
        check("abs3_cur", int'(cur_phase), 3);

        // Saturation at the top.
        load(1'b0, 250);
        wait_idle(4000);
        load(1'b1, 20);
        check("sat_tgt", int'(tgt_phase), 255);
        wait_idle(400);
        check("sat_cur", int'(cur_phase), 255);

        // Retarget while the second of five increments is in flight.
        load(1'b0, 0);
        wait_idle(4000);
        c0 = en_count;
        load(1'b0, 5);
        wait_en(50);
        @(negedge dcm_clk);
        wait_en(50);
        load(1'b0, -2);
        wait_idle(400);
        check("retgt_pulses", en_count - c0, 6);
        check("retgt_cur", int'(cur_phase), -2);

        // Loss of lock mid-walk.
        load(1'b0, 0);
        wait_idle(200);
        load(1'b0, 10);
        n = 0;
        while (int'(cur_phase) != 4 && n < 200) begin
            @(negedge dcm_clk);
            n++;
        end
        check("lock_reach4", int'(cur_phase), 4);
        wait_en(50);
        repeat (2) @(negedge dcm_clk);
        locked = 1'b0;
        c0 = en_count;
        repeat (8) @(negedge dcm_clk);
        check("lock_cur0", int'(cur_phase), 0);
        check("lock_no_en", en_count - c0, 0);
        check("lock_tgt_kept", int'(tgt_phase), 10);
        c1 = en_count;
        locked = 1'b1;
        wait_idle(400);
        check("relock_pulses", en_count - c1, 10);
        check("relock_cur", int'(cur_phase), 10);

        // Randomized loads with random PSDONE latency.
        rand_lat = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rel = 1'(($urandom_range(0, 1)));
            v   = int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 9) == 0) v = ($urandom_range(0, 1) != 0) ? 255 : -256;
            load(rel, v);
            repeat ($urandom_range(0, 12)) @(negedge dcm_clk);
            if (i % 4 == 3) wait_idle(6000);
        end
        wait_idle(6000);
        check("rand_final", int'(cur_phase), drv_tgt);
        rand_lat = 1'b0;
        lat      = 4;

`ifdef DCM_PHASE_TIMEOUT_EN
        load(1'b0, 0);
        wait_idle(6000);
        saved = int'(cur_phase);
        never_respond = 1'b1;
        load(1'b1, 1);
        wait_en(50);
        n = 0;
        while (!err && n < TMO + 50) begin
            @(negedge dcm_clk);
            n++;
        end
        check("tmo_err", int'(err), 1);
        check("tmo_cycles", n, TMO + 1);
        check("tmo_cur", int'(cur_phase), saved);
        clr_err = 1'b1;
        @(negedge dcm_clk);
        clr_err = 1'b0;
        check("tmo_clr", int'(err), 0);
        never_respond = 1'b0;
        wait_idle(400);
        check("tmo_retry_cur", int'(cur_phase), saved + 1);
`else
        saved = 0;
`endif

        // Asynchronous reset in the middle of a step.
        load(1'b0, 0);
        wait_idle(6000);
        load(1'b0, 5);
        wait_en(50);
        repeat (2) @(negedge dcm_clk);
        #2 dcm_rst = 1'b1;
        #1;
        check("arst_cur", int'(cur_phase), 0);
        check("arst_tgt", int'(tgt_phase), 0);
        check("arst_en", int'(dcm_en), 0);
        check("arst_incdec", int'(dcm_incdec), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_err", int'(err), 0);
        drv_tgt = 0;
        @(negedge dcm_clk);
        dcm_rst = 1'b0;
        c0 = en_count;
        repeat (20) @(negedge dcm_clk);
        check("arst_no_en", en_count - c0, 0);
        load(1'b0, 2);
        wait_idle(200);
        check("arst_recover", int'(cur_phase), 2 + saved - saved);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
